rs485_tx_ctrl: RTL
==================

// Module: rs485_tx_ctrl
// PURPOSE
//  Half-duplex RS-485 transmit sequencer driven by the 16x baud-tick from rs485_baud_gen.
//  Accepts bytes on a valid/ready handshake, serialises start/data/parity/stop on txd.
//  Owns transceiver direction: de (driver enable), re_n (receiver disable) with lead/trail guards.
//  Sits between the frame-producing logic and the RS-485 PHY pins.
// PARAMETERS
//  OVS        16  baud_ticks per bit (oversample ratio); must be >=2
//  DE_LEAD    16  baud_ticks de is high before start bit; 0 = start immediately
//  DE_TRAIL   16  baud_ticks de held after last stop bit; 0 = release immediately
//  STOP_BITS  1   stop bits per frame, 1 or 2
//  PARITY_EN  0   1 = insert parity bit after data
//  PARITY_ODD 0   1 = odd parity, 0 = even (ignored if PARITY_EN=0)
// PORTS
//  clk        in   1  system clock; single clock domain
//  reset      in   1  asynchronous, active-low reset
//  baud_tick  in   1  one-clk pulse at 16x baud (bclk of rs485_baud_gen); may be held high
//  tx_data    in   8  byte to send, LSB first
//  tx_valid   in   1  tx_data valid
//  tx_ready   out  1  block can accept a byte this cycle
//  txd        out  1  serial line, idle high
//  de         out  1  driver enable, active high
//  re_n       out  1  receiver enable, active low; equals de (rx off while driving)
//  busy       out  1  state != IDLE
//  tx_done    out  1  one-clk pulse when last stop bit completes
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE, txd=1, de=0, re_n=0, busy=0, tx_done=0, counters 0;
//   tx_ready=1 from first clk edge after reset release. Reset mid-frame aborts at once.
//  States: IDLE, LEAD, START, DATA, PARITY, STOP, TRAIL.
//  Handshake: byte accepted on clk edge with tx_valid & tx_ready; tx_data latched into shift reg.
//  tx_ready = 1 in IDLE and TRAIL only; 0 elsewhere (no input buffering).
//  tick_cnt counts baud_ticks 0..OVS-1, cleared on every state entry; advances only on baud_tick.
//  IDLE  -accept-> LEAD (de=1 next cycle); if DE_LEAD=0 -> START directly.
//  LEAD  : txd=1, de=1; after DE_LEAD baud_ticks -> START.
//  START : txd=0 for OVS ticks -> DATA, bit_idx=0.
//  DATA  : txd=shift[0]; each OVS ticks shift right, bit_idx++; after bit 7 -> PARITY or STOP.
//  PARITY: txd = ^data ^ PARITY_ODD for OVS ticks -> STOP.
//  STOP  : txd=1 for OVS*STOP_BITS ticks; tx_done pulses the cycle the state is left -> TRAIL
//          (DE_TRAIL=0 and no pending accept -> IDLE).
//  TRAIL : txd=1, de=1; accept -> START (no LEAD, de stays high, back-to-back frames);
//          else after DE_TRAIL ticks -> IDLE, de=0 the following cycle.
//  Accept and trail expiry in the same cycle: accept wins.
//  First tick period of a state is partial (entry not tick-aligned): bit length OVS-1..OVS ticks.
//  baud_tick held high: every clk is a tick (bit = OVS clks).
//  txd, de, re_n registered; glitch-free; de never falls while txd=0.
//  tx_data/tx_valid ignored outside handshake; data changes after accept have no effect.
// STRUCTURE
//  Package rs485_pkg: state enum, RS485_OVS_DEF=16, RS485_DATA_W=8 shared with rx side.
//  One sub-module natural: rs485_bit_timer (tick counter, clear/terminal-count at N ticks),
//   reused for guard, bit and stop timing.
//  Pure FSM + shifter otherwise; no clock gating, no derived clocks.
// TESTING  (OVS=16, DE_LEAD=DE_TRAIL=16, baud_tick every 4 clks unless stated)
//  Single byte 0xA5 -> de rises 1 clk after accept; 64 clk lead; txd 0,1,0,1,0,0,1,0,1,1; tx_done once.
//  Back-to-back 0x00,0xFF (2nd valid in TRAIL) -> no de drop, no LEAD on 2nd frame, start bit follows.
//  PARITY_EN=1: 0x07 even -> parity 1; PARITY_ODD=1 -> parity 0; STOP_BITS=2 -> stop 32 ticks.
//  DE_LEAD=0, DE_TRAIL=0, baud_tick tied high -> frame 160 clks, de=0 the clk after stop.
//  Reset pulse during DATA bit 3 -> txd=1, de=0, re_n=0 immediately; tx_ready=1 after release.
//  tx_valid held high in LEAD/DATA -> tx_ready=0, no second accept until TRAIL/IDLE.

Source files
------------

// File: rtl/rs485_pkg.sv
// Shared RS-485 definitions for the transmit and receive sides.
package rs485_pkg;

  localparam int RS485_OVS_DEF = 16;
  localparam int RS485_DATA_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEAD   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5,
    ST_TRAIL  = 3'd6
  } rs485_state_e;

  function automatic logic rs485_parity(input logic [RS485_DATA_W-1:0] data,
                                        input logic                    odd);
    return (^data) ^ odd;
  endfunction

  function automatic int rs485_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rs485_bit_timer.sv
// Baud-tick counter with clear and a terminal-count strobe; one instance
// times guard, bit and stop periods by switching i_last.
module rs485_bit_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_tick,
  input  logic [CNT_W-1:0] i_last,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  assign o_done = i_tick && (r_cnt == i_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rs485_tx_ctrl.sv
// Half-duplex RS-485 transmit sequencer: byte handshake, start/data/parity/stop
// serialisation and driver-enable lead/trail guard timing.
module rs485_tx_ctrl
  import rs485_pkg::*;
#(
  parameter int OVS        = RS485_OVS_DEF,
  parameter int DE_LEAD    = 16,
  parameter int DE_TRAIL   = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    baud_tick,
  input  logic [RS485_DATA_W-1:0] tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic                    txd,
  output logic                    de,
  output logic                    re_n,
  output logic                    busy,
  output logic                    tx_done
);

  localparam int STOP_TICKS = OVS * STOP_BITS;
  localparam int MAX_TICKS  = rs485_max3(STOP_TICKS, DE_LEAD, DE_TRAIL);
  localparam int CNT_W      = (MAX_TICKS > 2) ? $clog2(MAX_TICKS) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(OVS - 1);
  localparam logic [CNT_W-1:0] STOP_LAST  = CNT_W'(STOP_TICKS - 1);
  localparam logic [CNT_W-1:0] LEAD_LAST  = CNT_W'((DE_LEAD  > 0) ? DE_LEAD  - 1 : 0);
  localparam logic [CNT_W-1:0] TRAIL_LAST = CNT_W'((DE_TRAIL > 0) ? DE_TRAIL - 1 : 0);
  localparam logic             PAR_ODD    = (PARITY_ODD != 0);

  rs485_state_e              r_state;
  rs485_state_e              w_state_nxt;
  logic [RS485_DATA_W-1:0]   r_shift;
  logic [RS485_DATA_W-1:0]   w_shift_nxt;
  logic                      r_par;
  logic [2:0]                r_bit_idx;
  logic [2:0]                w_bit_idx_nxt;
  logic                      r_txd;
  logic                      r_de;
  logic                      r_ready;
  logic                      r_busy;
  logic                      r_done;
  logic                      w_txd_nxt;
  logic                      w_done_nxt;
  logic                      w_accept;
  logic                      w_tmr_done;
  logic                      w_tmr_clr;
  logic                      w_bit_end;
  logic [CNT_W-1:0]          w_tmr_last;

  assign w_accept  = tx_valid && r_ready;
  assign w_bit_end = (r_state == ST_DATA) && w_tmr_done;

  always_comb begin
    case (r_state)
      ST_LEAD:  w_tmr_last = LEAD_LAST;
      ST_STOP:  w_tmr_last = STOP_LAST;
      ST_TRAIL: w_tmr_last = TRAIL_LAST;
      default:  w_tmr_last = BIT_LAST;
    endcase
  end

  // Restart the count on every state entry and on each data-bit boundary.
  assign w_tmr_clr = (r_state == ST_IDLE) || (w_state_nxt != r_state) || w_bit_end;

  rs485_bit_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_tmr_clr),
    .i_tick (baud_tick),
    .i_last (w_tmr_last),
    .o_done (w_tmr_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (DE_LEAD == 0) ? ST_START : ST_LEAD;
        end
      end
      ST_LEAD: begin
        if (w_tmr_done) begin
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_tmr_done) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_tmr_done && (r_bit_idx == 3'd7)) begin
          w_state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (w_tmr_done) begin
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_tmr_done) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = (DE_TRAIL == 0) ? ST_IDLE : ST_TRAIL;
        end
      end
      ST_TRAIL: begin
        // A new byte wins over guard expiry and skips the lead guard.
        if (w_accept) begin
          w_state_nxt = ST_START;
        end else if (w_tmr_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_shift_nxt = r_shift;
    if (w_accept) begin
      w_shift_nxt = tx_data;
    end else if (w_bit_end) begin
      w_shift_nxt = r_shift >> 1;
    end
  end

  always_comb begin
    w_bit_idx_nxt = r_bit_idx;
    if ((w_state_nxt == ST_DATA) && (r_state != ST_DATA)) begin
      w_bit_idx_nxt = 3'd0;
    end else if (w_bit_end) begin
      w_bit_idx_nxt = r_bit_idx + 3'd1;
    end
  end

  // Line level is decoded from the next state so txd changes on the same edge as the state.
  always_comb begin
    case (w_state_nxt)
      ST_START:  w_txd_nxt = 1'b0;
      ST_DATA:   w_txd_nxt = w_shift_nxt[0];
      ST_PARITY: w_txd_nxt = r_par;
      default:   w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_bit_idx <= 3'd0;
      r_txd     <= 1'b1;
      r_de      <= 1'b0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_txd     <= w_txd_nxt;
      r_de      <= (w_state_nxt != ST_IDLE);
      r_ready   <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_TRAIL);
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_done    <= w_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
    if (w_accept) begin
      r_par <= rs485_parity(tx_data, PAR_ODD);
    end
  end

  assign tx_ready = r_ready;
  assign txd      = r_txd;
  assign de       = r_de;
  assign re_n     = r_de;
  assign busy     = r_busy;
  assign tx_done  = r_done;

endmodule
